pc_fetch_unit: RTL and testbench

Program-counter and fetch-control stage sitting directly upstream of the instruction ROM: it owns the PC register whose value drives the ROM's `InstAddress` each cycle. It sequences start, sequential fetch, absolute/relative branches (targets resolved through a small lookup table) and halt. It also exposes a run-state handshake (`Done`) and a retired-cycle counter for the testbench.

---
 rtl/pc_fetch_unit_pkg.sv | 45 ++++
 rtl/pc_fetch_unit_if.sv | 35 +++
 rtl/pc_fetch_unit_branch_lut.sv | 26 ++
 rtl/pc_fetch_unit.sv | 95 +++++++++
 tb/tb_pc_fetch_unit.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Purpose : shared types, default widths and branch-target table contents for the fetch stage.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: fetch_state_t (IDLE/RUN/HALTED), default widths A_W/D_W/C_W,
//           lut_init() giving the power-on value of each branch-table entry.
package pc_fetch_unit_pkg;

  // Default widths: PC/ROM address, branch-table index, cycle counter.
  localparam int A_W = 10;
  localparam int D_W = 4;
  localparam int C_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Branch-table contents, one entry per index. The same value serves either
  // as an absolute target or as a two's-complement offset, depending on the
  // BranchAbs flag of the instruction using it. Negative values truncate to
  // their A-bit two's-complement form in the table.
  function automatic int lut_init(input int idx);
    case (idx)
      0:       return 0;
      1:       return 100;
      2:       return 1;
      3:       return -4;
      4:       return -1;
      5:       return 40;
      6:       return 3;
      7:       return 512;
      8:       return 1023;
      9:       return 1;
      10:      return 12;
      11:      return -511;
      12:      return 20;
      13:      return -512;
      14:      return 300;
      15:      return 7;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Purpose : control/fetch bundle between the decoder/control side and the fetch stage.
// Latency : n/a (wires only).
// Backpressure: none; every signal is sampled or driven each cycle.
// Ports   : master drives Start/StartAddr/BranchEn/BranchAbs/BranchIdx/Halt and
//           observes InstAddress/Running/Done/CycleCount; slave is the fetch unit.
interface pc_fetch_unit_if
  import pc_fetch_unit_pkg::*;
#(
  parameter int A = A_W,
  parameter int D = D_W,
  parameter int C = C_W
);

  logic         Start;
  logic [A-1:0] StartAddr;
  logic         BranchEn;
  logic         BranchAbs;
  logic [D-1:0] BranchIdx;
  logic         Halt;
  logic [A-1:0] InstAddress;
  logic         Running;
  logic         Done;
  logic [C-1:0] CycleCount;

  modport master (
    output Start, StartAddr, BranchEn, BranchAbs, BranchIdx, Halt,
    input  InstAddress, Running, Done, CycleCount
  );

  modport slave (
    input  Start, StartAddr, BranchEn, BranchAbs, BranchIdx, Halt,
    output InstAddress, Running, Done, CycleCount
  );

endinterface

// File: rtl/pc_fetch_unit_branch_lut.sv
// Purpose : branch-target table, 2**D entries of A bits, read combinationally.
// Latency : 0 cycles (pure mux on BranchIdx).
// Backpressure: none.
// Ports   : BranchIdx (D) in -> Entry (A) out, absolute target or signed offset.
module pc_fetch_unit_branch_lut
  import pc_fetch_unit_pkg::*;
#(
  parameter int A = A_W,
  parameter int D = D_W
) (
  input  logic [D-1:0] BranchIdx,
  output logic [A-1:0] Entry
);

  // Contents are elaborated from the package table, so the ROM is a constant
  // mux with no storage and no dependence on an external load file.
  logic [A-1:0] table_q [2**D];

  always_comb begin
    for (int i = 0; i < 2**D; i++) begin
      table_q[i] = A'(lut_init(i));
    end
    Entry = table_q[BranchIdx];
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Purpose : PC register and fetch sequencer (start, increment, abs/rel branch, halt) feeding the ROM.
// Latency : decisions sampled at edge n appear on InstAddress/Running/Done/CycleCount after edge n.
// Backpressure: none; Start is only honoured in IDLE/HALTED, Halt/BranchEn only in RUN.
// Ports   : Clk, Reset (async, active-high); bus (slave) carries control inputs and
//           InstAddress (registered PC), Running, Done, CycleCount (saturating).
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int A = A_W,
  parameter int D = D_W,
  parameter int C = C_W
) (
  input  logic           Clk,
  input  logic           Reset,
  pc_fetch_unit_if.slave bus
);

  localparam logic [C-1:0] CNT_MAX = {C{1'b1}};

  fetch_state_t state;
  logic [A-1:0] pc;
  logic [C-1:0] cycle_count;
  logic         running;
  logic         done;

  logic [A-1:0] lut_entry;
  logic [A-1:0] branch_target;
  logic [A-1:0] run_next_pc;

  pc_fetch_unit_branch_lut #(
    .A (A),
    .D (D)
  ) u_branch_lut (
    .BranchIdx (bus.BranchIdx),
    .Entry     (lut_entry)
  );

  // Next PC while running, excluding halt (halt only freezes the PC).
  // Adding the raw A-bit entry modulo 2**A is identical to adding its
  // sign-extended value, so no explicit extension is needed.
  always_comb begin
    branch_target = bus.BranchAbs ? lut_entry : (pc + lut_entry);
    run_next_pc   = bus.BranchEn  ? branch_target : (pc + A'(1));
  end

  // Single FSM block; Running/Done are registered alongside the state so
  // they switch on the same edge as the transition.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      pc          <= '0;
      cycle_count <= '0;
      running     <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (bus.Start) begin
            state       <= RUN;
            pc          <= bus.StartAddr;
            cycle_count <= '0;
            running     <= 1'b1;
            done        <= 1'b0;
          end
        end

        RUN: begin
          // The halting cycle is still a RUN cycle and is counted.
          if (cycle_count != CNT_MAX) begin
            cycle_count <= cycle_count + C'(1);
          end
          if (bus.Halt) begin
            state   <= HALTED;
            running <= 1'b0;
            done    <= 1'b1;
          end else begin
            pc <= run_next_pc;
          end
        end

        default: begin
          state   <= IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.InstAddress = pc;
  assign bus.Running     = running;
  assign bus.Done        = done;
  assign bus.CycleCount  = cycle_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Purpose : self-checking bench for pc_fetch_unit: directed vector table, async-reset,
//           held-Start and counter-saturation sequences, then random stimulus vs a model.
// Latency : outputs checked 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_pc_fetch_unit;

  localparam int AW   = 10;
  localparam int DW   = 4;
  localparam int AMOD = 1024;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  // Branch table as the program sees it: signed values.
  int tb_lut [16] = '{0, 100, 1, -4, -1, 40, 3, 512, 1023, 1, 12, -511, 20, -512, 300, 7};

  pc_fetch_unit_if #(.A(AW), .D(DW), .C(16)) bus0 ();
  pc_fetch_unit_if #(.A(AW), .D(DW), .C(4))  bus1 ();

  pc_fetch_unit #(.A(AW), .D(DW), .C(16)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus0)
  );

  pc_fetch_unit #(.A(AW), .D(DW), .C(4)) dut_sat (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       start;
    logic [9:0] addr;
    logic       br;
    logic       br_abs;
    logic [3:0] idx;
    logic       halt;
    int         pc;
    int         run;
    int         done;
    int         cnt;
  } vec_t;

  vec_t vecs [17];

  function automatic int wrap(input int x);
    return ((x % AMOD) + AMOD) % AMOD;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int pc, input int run, input int done, input int cnt);
    chk({tag, ".pc"},   int'(bus0.InstAddress), pc);
    chk({tag, ".run"},  int'(bus0.Running),     run);
    chk({tag, ".done"}, int'(bus0.Done),        done);
    chk({tag, ".cnt"},  int'(bus0.CycleCount),  cnt);
  endtask

  task automatic drive(input logic s, input logic [9:0] a, input logic b, input logic ba,
                       input logic [3:0] i, input logic h);
    bus0.Start     = s;
    bus0.StartAddr = a;
    bus0.BranchEn  = b;
    bus0.BranchAbs = ba;
    bus0.BranchIdx = i;
    bus0.Halt      = h;
  endtask

  initial begin
    logic       r_start, r_br, r_abs, r_halt;
    logic [9:0] r_addr;
    logic [3:0] r_idx;
    bit         m_run, m_halted;
    int         m_pc, m_cnt, exp_cnt;

    //            start addr   br   abs  idx  halt   pc  run done cnt
    vecs[0]  = '{1'b1, 10'd5, 1'b0, 1'b0, 4'd0,  1'b0,    5, 1, 0,  0};
    vecs[1]  = '{1'b0, 10'd0, 1'b0, 1'b0, 4'd0,  1'b0,    6, 1, 0,  1};
    vecs[2]  = '{1'b0, 10'd0, 1'b0, 1'b0, 4'd0,  1'b0,    7, 1, 0,  2};
    vecs[3]  = '{1'b0, 10'd0, 1'b0, 1'b0, 4'd0,  1'b0,    8, 1, 0,  3};
    vecs[4]  = '{1'b0, 10'd0, 1'b1, 1'b1, 4'd2,  1'b0,    1, 1, 0,  4};
    vecs[5]  = '{1'b0, 10'd0, 1'b1, 1'b1, 4'd12, 1'b0,   20, 1, 0,  5};
    vecs[6]  = '{1'b0, 10'd0, 1'b1, 1'b0, 4'd3,  1'b0,   16, 1, 0,  6};
    vecs[7]  = '{1'b0, 10'd0, 1'b1, 1'b1, 4'd0,  1'b0,    0, 1, 0,  7};
    vecs[8]  = '{1'b0, 10'd0, 1'b1, 1'b0, 4'd4,  1'b0, 1023, 1, 0,  8};
    vecs[9]  = '{1'b0, 10'd0, 1'b0, 1'b0, 4'd0,  1'b0,    0, 1, 0,  9};
    vecs[10] = '{1'b0, 10'd0, 1'b1, 1'b1, 4'd10, 1'b0,   12, 1, 0, 10};
    vecs[11] = '{1'b0, 10'd0, 1'b1, 1'b1, 4'd2,  1'b1,   12, 0, 1, 11};
    vecs[12] = '{1'b0, 10'd0, 1'b1, 1'b1, 4'd2,  1'b0,   12, 0, 1, 11};
    vecs[13] = '{1'b0, 10'd0, 1'b0, 1'b0, 4'd0,  1'b1,   12, 0, 1, 11};
    vecs[14] = '{1'b1, 10'd0, 1'b0, 1'b0, 4'd0,  1'b0,    0, 1, 0,  0};
    vecs[15] = '{1'b1, 10'd7, 1'b0, 1'b0, 4'd0,  1'b0,    1, 1, 0,  1};
    vecs[16] = '{1'b0, 10'd0, 1'b1, 1'b0, 4'd6,  1'b0,    4, 1, 0,  2};

    rst = 1'b1;
    drive(1'b0, 10'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    bus1.Start     = 1'b0;
    bus1.StartAddr = '0;
    bus1.BranchEn  = 1'b0;
    bus1.BranchAbs = 1'b0;
    bus1.BranchIdx = '0;
    bus1.Halt      = 1'b0;

    // Reset state.
    step();
    chk_all("reset", 0, 0, 0, 0);
    chk("reset.sat_cnt", int'(bus1.CycleCount), 0);
    rst = 1'b0;
    step();
    chk_all("idle", 0, 0, 0, 0);

    // Directed vector table.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].start, vecs[i].addr, vecs[i].br, vecs[i].br_abs, vecs[i].idx, vecs[i].halt);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].run, vecs[i].done, vecs[i].cnt);
    end

    // Halt, restart at 38, run to 40, then async reset between edges.
    drive(1'b0, 10'd0, 1'b0, 1'b0, 4'd0, 1'b1);
    step();
    chk_all("halt2", 4, 0, 1, 3);
    drive(1'b1, 10'd38, 1'b0, 1'b0, 4'd0, 1'b0);
    step();
    drive(1'b0, 10'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    step();
    step();
    chk_all("pre_rst", 40, 1, 0, 2);
    #3;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0);
    step();
    rst = 1'b0;
    drive(1'b0, 10'd0, 1'b1, 1'b1, 4'd1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all($sformatf("post_rst%0d", k), 0, 0, 0, 0);
    end

    // Start held high for five cycles loads StartAddr only once.
    drive(1'b1, 10'd100, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk_all($sformatf("held%0d", k), 100 + k, 1, 0, k);
    end
    drive(1'b0, 10'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    step();
    chk_all("held_rel", 105, 1, 0, 5);

    // 4-bit counter saturates at 15.
    bus1.Start     = 1'b1;
    bus1.StartAddr = 10'd3;
    step();
    bus1.Start = 1'b0;
    chk("sat.start_pc", int'(bus1.InstAddress), 3);
    chk("sat.start_cnt", int'(bus1.CycleCount), 0);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("sat.cnt%0d", k), int'(bus1.CycleCount), (k < 15) ? k : 15);
    end
    chk("sat.pc", int'(bus1.InstAddress), 23);
    chk("sat.run", int'(bus1.Running), 1);

    // Random stimulus against a behavioural model.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_run = 0; m_halted = 0; m_pc = 0; m_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      r_start = ($urandom_range(0, 7) == 0);
      r_addr  = 10'($urandom);
      r_br    = ($urandom_range(0, 3) == 0);
      r_abs   = 1'($urandom);
      r_idx   = 4'($urandom);
      r_halt  = ($urandom_range(0, 15) == 0);
      drive(r_start, r_addr, r_br, r_abs, r_idx, r_halt);
      if (!m_run) begin
        if (r_start) begin
          m_run = 1; m_halted = 0; m_pc = int'(r_addr); m_cnt = 0;
        end
      end else begin
        exp_cnt = m_cnt + 1;
        m_cnt = (exp_cnt > 65535) ? 65535 : exp_cnt;
        if (r_halt) begin
          m_run = 0; m_halted = 1;
        end else if (r_br) begin
          m_pc = r_abs ? wrap(tb_lut[r_idx]) : wrap(m_pc + tb_lut[r_idx]);
        end else begin
          m_pc = wrap(m_pc + 1);
        end
      end
      step();
      chk_all($sformatf("rand%0d", n), m_pc, int'(m_run), int'(m_halted), m_cnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
